// File: rtl/pipe_skid_reg.sv
// Two-slot skid pipeline register: main slot drives out_*, skid slot absorbs one beat of backpressure.
// Optional performance counters are enabled by defining PIPE_SKID_REG_PERF_EN.
module pipe_skid_reg #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int CMT_W   = 160
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_commit,
  input  logic [CMT_W-1:0]   in_cmt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_commit,
  output logic [CMT_W-1:0]   out_cmt
`ifdef PIPE_SKID_REG_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  logic               main_valid_r, skid_valid_r, in_ready_r, out_commit_r;
  logic [PC_W-1:0]    main_pc_r, skid_pc_r;
  logic [INSTR_W-1:0] main_instr_r, skid_instr_r;
  logic               main_commit_r, skid_commit_r;
  logic [CMT_W-1:0]   main_cmt_r, skid_cmt_r;

  logic               accept_s, xfer_s;
  logic               main_valid_nxt_s, skid_valid_nxt_s;
  logic               main_load_in_s, main_load_skid_s, skid_load_s;

  assign accept_s = in_valid & in_ready_r;
  assign xfer_s   = main_valid_r & out_ready;

  // Next-state decode for slot valids and load selects (flush handled here, rst in the flop block).
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!main_valid_r || xfer_s) begin
      if (skid_valid_r) begin
        main_load_skid_s = 1'b1;
        main_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        main_load_in_s   = 1'b1;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else begin
      // Main is stalled: an accepted beat parks in the skid slot.
      if (accept_s) begin
        skid_load_s      = 1'b1;
        skid_valid_nxt_s = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end
  end

  // Slot state, payload registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r  <= 1'b0;
      skid_valid_r  <= 1'b0;
      in_ready_r    <= 1'b1;
      out_commit_r  <= 1'b0;
      main_pc_r     <= {PC_W{1'b0}};
      main_instr_r  <= {INSTR_W{1'b0}};
      main_commit_r <= 1'b0;
      main_cmt_r    <= {CMT_W{1'b0}};
      skid_pc_r     <= {PC_W{1'b0}};
      skid_instr_r  <= {INSTR_W{1'b0}};
      skid_commit_r <= 1'b0;
      skid_cmt_r    <= {CMT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
      if (main_load_skid_s) begin
        main_pc_r     <= skid_pc_r;
        main_instr_r  <= skid_instr_r;
        main_commit_r <= skid_commit_r;
        main_cmt_r    <= skid_cmt_r;
        out_commit_r  <= skid_commit_r;
      end else if (main_load_in_s) begin
        main_pc_r     <= in_pc;
        main_instr_r  <= in_instr;
        main_commit_r <= in_commit;
        main_cmt_r    <= in_cmt;
        out_commit_r  <= in_commit;
      end else begin
        out_commit_r  <= main_valid_nxt_s & main_commit_r;
      end
      if (skid_load_s) begin
        skid_pc_r     <= in_pc;
        skid_instr_r  <= in_instr;
        skid_commit_r <= in_commit;
        skid_cmt_r    <= in_cmt;
      end else begin
        skid_pc_r     <= skid_pc_r;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign out_pc     = main_pc_r;
  assign out_instr  = main_instr_r;
  assign out_commit = out_commit_r;
  assign out_cmt    = main_cmt_r;

`ifdef PIPE_SKID_REG_PERF_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Stall and useful-flush event counters; wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (main_valid_r && !out_ready) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (main_valid_r || skid_valid_r)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`else
  // Counters compiled out; datapath is identical.
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 64, PC and commit-PC width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter CMT_W, default 160, opaque commit sideband width (commit_pc, commit_instr, commit_pre_pc packed).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  in  1  synchronous pipeline kill (branch/trap redirect).
REQ-007 SHALL have port in_valid  in  1  upstream payload valid.
REQ-008 SHALL have port in_ready  out  1  register can accept; driven only from a flop.
REQ-009 SHALL have ports in_pc, in_instr, in_commit, in_cmt  in  PC_W/INSTR_W/1/CMT_W  upstream payload.
REQ-010 SHALL have port out_valid  out  1  downstream payload valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts.
REQ-012 SHALL have ports out_pc, out_instr, out_commit, out_cmt  out  PC_W/INSTR_W/1/CMT_W  registered payload.

Function
REQ-013 SHALL hold two slots, main (drives out_*) and skid, each with a valid bit; in_ready = NOT skid_valid.
REQ-014 SHALL accept when in_valid AND in_ready; SHALL transfer downstream when out_valid AND out_ready.
REQ-015 SHALL present an accepted payload on out_* exactly 1 cycle after accept when main is empty or transferring.
REQ-016 SHALL load the skid slot on accept when main holds valid data and is not transferring.
REQ-017 SHALL move skid into main on a transfer cycle when skid is valid; skid then empties (no accept that cycle, in_ready was 0).
REQ-018 SHALL sustain 1 payload/cycle with out_ready held high; no bubble, no loss, no duplication, strict FIFO order.
REQ-019 SHALL, on flush, clear main_valid and skid_valid next cycle and drop any payload offered on the flush cycle; in_ready = 1 the cycle after.
REQ-020 SHALL force out_commit = 0 whenever out_valid = 0.
REQ-021 SHALL hold out_pc/out_instr/out_cmt stable while out_valid AND NOT out_ready (stall).
REQ-022 SHALL leave out_pc/out_instr/out_cmt unchanged when main empties without reload.

Reset
REQ-023 SHALL, with rst high, next cycle set out_valid 0, in_ready 1, out_pc/out_instr/out_cmt/out_commit 0, skid contents 0.
REQ-024 SHALL give rst priority over flush and over any accept/transfer in the same cycle; mid-stream reset discards both slots.

Configuration
REQ-025 SHALL, with macro PIPE_SKID_REG_PERF_EN defined, add outputs perf_stall_cnt (32) counting cycles out_valid AND NOT out_ready, and perf_flush_cnt (32) counting flush cycles in which any slot was valid; both reset to 0 and wrap 0xFFFFFFFF->0.
REQ-026 SHALL, without PIPE_SKID_REG_PERF_EN, omit those ports and counters entirely; datapath behaviour identical.

Verification
REQ-027 SHALL cover: reset then in_valid=1, in_pc=0x80000000, in_instr=0x00000013, out_ready=1 -> next cycle out_valid=1, out_pc=0x80000000, out_instr=0x00000013.
REQ-028 SHALL cover: out_ready=0, send pc 0x100 then 0x104 -> in_ready=0 after 2nd accept, out_pc=0x100 held; release out_ready -> 0x100, 0x104 in order, in_ready=1.
REQ-029 SHALL cover: 16 back-to-back payloads pc 0x0..0x3C step 4 with out_ready=1 -> 16 consecutive out_valid cycles, in order.
REQ-030 SHALL cover: both slots full (0x200, 0x204), flush=1 with in_valid=1 pc 0x208 -> next cycle out_valid=0, out_commit=0, in_ready=1, 0x208 never appears.
REQ-031 SHALL cover: rst and flush together while in_valid=1 -> all outputs per REQ-023; with PIPE_SKID_REG_PERF_EN, perf_flush_cnt stays 0.
REQ-032 SHALL cover (PIPE_SKID_REG_PERF_EN): out_valid=1, out_ready=0 for 5 cycles -> perf_stall_cnt=5.
